pipe_mem_arbiter: RTL and testbench

- Arbitrates one shared single-port memory between the pipeline's instruction-fetch port (IF, read-only) and the MEM-stage data port (DM, read/write).
- One transaction is in flight at a time. DM has priority, with an anti-starvation override for IF.
- Drives per-port stall signals that freeze the PC, IFID and the later pipeline registers.
- Has a bus timeout that flags an error and completes the stuck transaction.

---
 rtl/pipe_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_pipe_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one single-port memory between the instruction
// fetch port (IF, read-only) and the MEM-stage data port (DM, read/write).
// One transaction is in flight at a time. DM has priority, but IF wins a
// contested grant after STARVE_MAX consecutive losses. A bus timeout
// force-completes a stuck transaction with 32'hDEADBEEF and sets a sticky
// error flag.
module pipe_mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  // instruction fetch port
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_data_o,
  output logic        if_stall_o,
  // data memory port
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_ack_o,
  output logic [31:0] dm_rdata_o,
  output logic        dm_stall_o,
  // backend memory
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  // status
  output logic        owner_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT - 1);
  localparam logic [31:0]   TMO_DATA     = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;

  logic        want_grant;
  logic        grant_dm;
  logic        finish;
  logic [31:0] resp_data;

  // Grant decision in IDLE: DM first unless IF has hit the starvation limit.
  assign want_grant = start_i & (if_req_i | dm_req_i);
  assign grant_dm   = dm_req_i & ~(if_req_i & (starve_cnt == STARVE_LIMIT));

  // A backend ack takes precedence over a timeout landing in the same cycle.
  assign finish    = mem_ack_i | (tmo_cnt == TMO_LAST);
  assign resp_data = mem_ack_i ? mem_rdata_i : TMO_DATA;

  // Stalls are combinational so the pipeline freezes in the request cycle.
  assign if_stall_o = if_req_i & ~if_ack_o;
  assign dm_stall_o = dm_req_i & ~dm_ack_o;
  assign busy_o     = (state != IDLE);

  // Arbitration FSM with all outputs registered.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // a blocking write would leak a new value into later statements this edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      tmo_cnt     <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      if_data_o   <= '0;
      dm_ack_o    <= 1'b0;
      dm_rdata_o  <= '0;
      owner_o     <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      // Acks are single-cycle pulses unless re-armed below.
      if_ack_o <= 1'b0;
      dm_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (want_grant) begin
            owner_o     <= grant_dm;
            mem_req_o   <= 1'b1;
            mem_we_o    <= grant_dm & dm_we_i;
            mem_addr_o  <= grant_dm ? dm_addr_i : if_addr_i;
            mem_wdata_o <= grant_dm ? dm_wdata_i : 32'h0;
            tmo_cnt     <= '0;
            state       <= BUSY;
            if (grant_dm) begin
              if (if_req_i && (starve_cnt != STARVE_LIMIT))
                starve_cnt <= starve_cnt + SW'(1);
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        BUSY: begin
          if (finish) begin
            mem_req_o <= 1'b0;
            tmo_cnt   <= '0;
            state     <= RESP;
            if (!mem_ack_i) err_o <= 1'b1;
            if (owner_o) begin
              dm_rdata_o <= resp_data;
              dm_ack_o   <= 1'b1;
            end else begin
              if_data_o <= resp_data;
              if_ack_o  <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter: a table of single transactions
// followed by directed sequences for contention, starvation, timeout,
// asynchronous reset and the run enable.
module tb_pipe_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_data;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        owner;
  logic        busy;
  logic        err;

  pipe_mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(64)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_ack_o   (if_ack),
    .if_data_o  (if_data),
    .if_stall_o (if_stall),
    .dm_req_i   (dm_req),
    .dm_we_i    (dm_we),
    .dm_addr_i  (dm_addr),
    .dm_wdata_i (dm_wdata),
    .dm_ack_o   (dm_ack),
    .dm_rdata_o (dm_rdata),
    .dm_stall_o (dm_stall),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_ack_i  (mem_ack),
    .mem_rdata_i(mem_rdata),
    .owner_o    (owner),
    .busy_o     (busy),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] if_addr;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] rdata;
    int          delay;      // backend ack in cycle t+delay
    logic        exp_owner;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;  // checked on DM grants only
    logic [31:0] exp_data;   // checked on reads only
  } vec_t;

  vec_t vecs[6];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until mem_req is high, at most budget edges.
  task automatic wait_req(input string name, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (i < budget) tick();
    end
    if (!ok) check_b({name, " mem_req wait"}, 1'b0, 1'b1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag      = $sformatf("v%0d", idx);
    if_req   = v.if_req;
    dm_req   = v.dm_req;
    dm_we    = v.dm_we;
    if_addr  = v.if_addr;
    dm_addr  = v.dm_addr;
    dm_wdata = v.dm_wdata;
    #1;
    check_b({tag, " if_stall req"}, if_stall, v.if_req);
    tick();
    check_b({tag, " mem_req"}, mem_req, 1'b1);
    check_b({tag, " owner"}, owner, v.exp_owner);
    check_b({tag, " mem_we"}, mem_we, v.exp_we);
    check({tag, " mem_addr"}, mem_addr, v.exp_addr);
    if (v.exp_owner) check({tag, " mem_wdata"}, mem_wdata, v.exp_wdata);
    for (int i = 1; i < v.delay; i++) begin
      check_b({tag, " early ack"}, if_ack | dm_ack, 1'b0);
      tick();
    end
    mem_ack   = 1'b1;
    mem_rdata = v.rdata;
    tick();
    mem_ack = 1'b0;
    check_b({tag, " owner ack"}, v.exp_owner ? dm_ack : if_ack, 1'b1);
    check_b({tag, " other ack"}, v.exp_owner ? if_ack : dm_ack, 1'b0);
    check_b({tag, " mem_req drop"}, mem_req, 1'b0);
    check_b({tag, " other stall"}, v.exp_owner ? if_stall : dm_stall,
            v.exp_owner ? v.if_req : v.dm_req);
    if (!v.exp_we) check({tag, " rdata"}, v.exp_owner ? dm_rdata : if_data, v.exp_data);
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    check_b({tag, " idle"}, busy, 1'b0);
    check_b({tag, " ack fell"}, if_ack | dm_ack, 1'b0);
    if (!v.exp_we) check({tag, " rdata held"}, v.exp_owner ? dm_rdata : if_data, v.exp_data);
  endtask

  initial begin
    logic exp_order[10];
    int   seen;

    // if_req dm_req we if_addr dm_addr dm_wdata rdata delay | owner we addr wdata data
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h04, 32'h0, 32'h0, 32'h8C220000, 2,
                1'b0, 1'b0, 32'h04, 32'h0, 32'h8C220000};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h08, 32'h10, 32'h5, 32'h0, 1,
                1'b1, 1'b1, 32'h10, 32'h5, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0, 32'h12345678, 3,
                1'b1, 1'b0, 32'h20, 32'h0, 32'h12345678};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0C, 32'h24, 32'h0, 32'hA5A5A5A5, 1,
                1'b1, 1'b0, 32'h24, 32'h0, 32'hA5A5A5A5};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h00C0FFEE, 4,
                1'b0, 1'b0, 32'h100, 32'h0, 32'h00C0FFEE};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h30, 32'hCAFEF00D, 32'h0, 1,
                1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 32'h0};

    rst = 1'b1; start = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    check("reset outputs", {mem_req, mem_we, if_ack, dm_ack, owner, err, busy}, '0);
    check("reset data", if_data | dm_rdata | mem_addr | mem_wdata, '0);
    tick();
    tick();
    rst = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Simultaneous requests: DM served first, IF next, IF stalled throughout.
    if_req = 1'b1; if_addr = 32'h0C;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'h5;
    tick();
    check_b("both owner dm", owner, 1'b1);
    check_b("both we", mem_we, 1'b1);
    check("both wdata", mem_wdata, 32'h5);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_b("both dm_ack", dm_ack, 1'b1);
    check_b("both if_stall resp", if_stall, 1'b1);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    check_b("both if_stall idle", if_stall, 1'b1);
    tick();
    check_b("both if grant", mem_req & ~owner, 1'b1);
    check("both if addr", mem_addr, 32'h0C);
    check_b("both if_stall busy", if_stall, 1'b1);
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    tick();
    mem_ack = 1'b0;
    check_b("both if_ack", if_ack, 1'b1);
    check("both if_data", if_data, 32'h11112222);
    if_req = 1'b0;
    tick();

    // Continuous contention: IF wins after four straight losses.
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_addr = 32'h300;
    for (int g = 0; g < 10; g++) begin
      wait_req($sformatf("starve g%0d", g), 4);
      check_b($sformatf("starve g%0d owner", g), owner, exp_order[g]);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick();

    // Timeout: no backend ack for 64 BUSY cycles.
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    check_b("tmo busy entry", mem_req, 1'b1);
    repeat (63) tick();
    check_b("tmo no ack at 63", if_ack, 1'b0);
    check_b("tmo no err at 63", err, 1'b0);
    tick();
    check_b("tmo ack at 64", if_ack, 1'b1);
    check_b("tmo err", err, 1'b1);
    check("tmo data", if_data, 32'hDEADBEEF);
    check_b("tmo mem_req drop", mem_req, 1'b0);
    if_req = 1'b0;
    tick();
    run_vec(6, '{1'b0, 1'b1, 1'b0, 32'h0, 32'h44, 32'h0, 32'h0BADF00D, 2,
                 1'b1, 1'b0, 32'h44, 32'h0, 32'h0BADF00D});
    check_b("tmo err sticky", err, 1'b1);

    // Asynchronous reset while BUSY, then a held IF request is granted.
    if_req = 1'b1; if_addr = 32'h50;
    tick();
    check_b("rst pre mem_req", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst async flags", {mem_req, mem_we, if_ack, dm_ack, owner, err, busy}, '0);
    check("rst async data", if_data | dm_rdata | mem_addr | mem_wdata, '0);
    #2 rst = 1'b0;
    tick();
    check_b("rst regrant", mem_req & ~owner, 1'b1);
    check("rst regrant addr", mem_addr, 32'h50);
    mem_ack = 1'b1; mem_rdata = 32'h0000ABCD;
    tick();
    mem_ack = 1'b0;
    check_b("rst if_ack", if_ack, 1'b1);
    if_req = 1'b0;
    tick();

    // Run enable low blocks grants even with both requests pending.
    start = 1'b0;
    if_req = 1'b1; dm_req = 1'b1; dm_addr = 32'h60;
    seen = 0;
    repeat (10) begin
      tick();
      if (mem_req) seen++;
    end
    check("start low grants", seen, 0);
    start = 1'b1;
    tick();
    check_b("start dm grant", mem_req & owner, 1'b1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_b("start dm_ack", dm_ack, 1'b1);
    if_req = 1'b0; dm_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
